// File: rtl/live_cell_pkg.sv
`default_nettype none
// ============================================================================
// Module      : live_cell_pkg
// Description : Shared FSM state encoding and index-width helper for the
//               live cell encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package live_cell_pkg;

    typedef logic [0:0] state_t;

    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_EMIT = 1'b1;

    // Index width for an n-wide row; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Index of the lowest set bit of a vector (highest when
//               LIVE_CELL_ENCODER_MSB_FIRST_EN is defined) plus an any flag.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder
    import live_cell_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
`ifdef LIVE_CELL_ENCODER_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = i[W-1:0];
        end
`else
        // Scanning downward lets the lowest set bit win the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[W-1:0];
        end
`endif
    end

    assign any = |vec;

endmodule
`default_nettype wire

// File: rtl/live_cell_encoder.sv
`default_nettype none
// ============================================================================
// Module      : live_cell_encoder
// Description : Streams the column indices of the live cells in a row, one
//               per valid/ready beat. Define LIVE_CELL_ENCODER_MSB_FIRST_EN
//               for descending index order.
// Revision    : 1.0 - initial release
// ============================================================================
module live_cell_encoder
    import live_cell_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic         out_last
);

    localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         enc_any;
    logic         single_left;

    priority_encoder #(.N(N)) u_enc (
        .vec (pending_q),
        .idx (out_index),
        .any (enc_any)
    );

    assign single_left = enc_any && ((pending_q & (pending_q - C_ONE)) == '0);
    assign out_valid   = (state_q == S_EMIT);
    assign out_last    = out_valid && single_left;
    assign in_ready    = rst && ((state_q == S_IDLE) || (out_valid && out_ready && out_last));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (out_valid && out_ready) begin
            pending_d = pending_q & ~(C_ONE << out_index);
            if (out_last) state_d = S_IDLE;
        end
        // A row accepted on the final beat overrides the clear above.
        if (in_valid && in_ready) begin
            pending_d = in_data;
            state_d   = (in_data != '0) ? S_EMIT : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_live_cell_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_live_cell_encoder
// Description : Self-checking bench: directed rows with literal expectations
//               plus randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_live_cell_encoder;

    localparam int N = 8;
    localparam int W = 3;

`ifdef LIVE_CELL_ENCODER_MSB_FIRST_EN
    localparam logic [W-1:0] C_B0 = 3'd7, C_B1 = 3'd5, C_B2 = 3'd2;
    localparam logic [W-1:0] C_P0 = 3'd2, C_P1 = 3'd1, C_FF0 = 3'd7;
`else
    localparam logic [W-1:0] C_B0 = 3'd2, C_B1 = 3'd5, C_B2 = 3'd7;
    localparam logic [W-1:0] C_P0 = 3'd1, C_P1 = 3'd2, C_FF0 = 3'd0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_index;
    logic         out_last;

    int n_checks = 0;
    int n_fail   = 0;

    live_cell_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference model: the indices still owed for the current row, in order.
    int  m_q[$];
    bit  m_started = 1'b0;
    bit  m_pop, m_acc;

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_started = 1'b1;
        end else if (m_started) begin
            m_pop = (m_q.size() > 0) && out_ready;
            m_acc = in_valid && ((m_q.size() == 0) || (out_ready && m_q.size() == 1));
            if (m_pop) void'(m_q.pop_front());
            if (m_acc) begin
`ifdef LIVE_CELL_ENCODER_MSB_FIRST_EN
                for (int i = N - 1; i >= 0; i--) if (in_data[i]) m_q.push_back(i);
`else
                for (int i = 0; i < N; i++) if (in_data[i]) m_q.push_back(i);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("mdl_in_ready", int'(in_ready),
                  int'(rst && (m_q.size() == 0 || (out_ready && m_q.size() == 1))));
            check("mdl_out_valid", int'(out_valid), int'(m_q.size() > 0));
            check("mdl_out_index", int'(out_index), (m_q.size() > 0) ? m_q[0] : 0);
            check("mdl_out_last", int'(out_last), int'(m_q.size() == 1));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string name, input logic [W-1:0] idx, input logic last);
        @(negedge clk);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_index"}, int'(out_index), int'(idx));
        check({name, "_last"}, int'(out_last), int'(last));
    endtask

    task automatic chk_idle(input string name, input logic rdy);
        @(negedge clk);
        check({name, "_valid"}, int'(out_valid), 0);
        check({name, "_ready"}, int'(in_ready), int'(rdy));
    endtask

    initial begin
        // Reset held with in_valid high.
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        next();
        next();
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_last", int'(out_last), 0);
        next();
        rst = 1'b1; in_valid = 1'b0;
        chk_idle("post_rst", 1'b1);

        // Basic row.
        next();
        in_valid = 1'b1; in_data = 8'b1010_0100;
        next();
        in_valid = 1'b0;
        chk_beat("basic0", C_B0, 1'b0);
        next();
        chk_beat("basic1", C_B1, 1'b0);
        next();
        chk_beat("basic2", C_B2, 1'b1);
        next();
        chk_idle("basic_done", 1'b1);

        // Empty row.
        in_valid = 1'b1; in_data = 8'h00;
        next();
        in_valid = 1'b0;
        chk_idle("empty", 1'b1);

        // Backpressure.
        next();
        in_valid = 1'b1; in_data = 8'b0000_0110; out_ready = 1'b0;
        next();
        in_valid = 1'b0;
        chk_beat("bp_hold0", C_P0, 1'b0);
        next();
        chk_beat("bp_hold1", C_P0, 1'b0);
        next();
        chk_beat("bp_hold2", C_P0, 1'b0);
        next();
        out_ready = 1'b1;
        chk_beat("bp_rel0", C_P0, 1'b0);
        next();
        chk_beat("bp_rel1", C_P1, 1'b1);
        next();
        chk_idle("bp_done", 1'b1);

        // Back-to-back single-cell rows.
        in_valid = 1'b1; in_data = 8'h80;
        next();
        in_data = 8'h01;
        chk_beat("b2b0", 3'd7, 1'b1);
        check("b2b_in_ready", int'(in_ready), 1);
        next();
        in_valid = 1'b0;
        chk_beat("b2b1", 3'd0, 1'b1);
        next();
        chk_idle("b2b_done", 1'b1);

        // Full row interrupted by reset after its first beat.
        in_valid = 1'b1; in_data = 8'hFF;
        next();
        in_valid = 1'b0;
        chk_beat("ff0", C_FF0, 1'b0);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 0);
        next();
        rst = 1'b1;
        chk_idle("midrst0", 1'b1);
        next();
        chk_idle("midrst1", 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            next();
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) != 0);
        end
        next();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
